// File: rtl/shift_register_pkg.sv
// shift_register_pkg: shared state encoding and defaults for the shift register scheduler
package shift_register_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_register_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  int j;
  // Walk offsets from farthest to nearest so the nearest set request wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/shift_register_scheduler.sv
// shift_register_scheduler: arbitrates requesters onto one shift register and sequences load/shift/capture
module shift_register_scheduler
  import shift_register_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ = 2,
  parameter int SHIFTS = WIDTH
) (
  input  logic                    C,
  input  logic                    R,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ*WIDTH-1:0]   DIN,
  input  logic [WIDTH-1:0]        Q,
  output logic                    L,
  output logic                    SE,
  output logic [WIDTH-1:0]        D,
  output logic [NREQ-1:0]         GNT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [WIDTH-1:0]        RESULT
);
  localparam int CW = SHIFTS > 0 ? $clog2(SHIFTS + 1) : 1;
  localparam int IW = $clog2(NREQ);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, win_idx, arb_idx;
  logic [NREQ-1:0] win_oh, arb_oh, gnt_n;
  logic l_n, se_n, done_n, busy_n;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(REQ), .ptr(ptr), .gnt(arb_oh), .idx(arb_idx));
  always_ff @(posedge C) state <= R ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |REQ ? LOAD : IDLE;
      LOAD:    nxt = SHIFTS > 0 ? SHIFT : shift_register_pkg::DONE;
      SHIFT:   nxt = cnt == CW'(1) ? shift_register_pkg::DONE : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    l_n = nxt == LOAD;
    se_n = nxt == SHIFT;
    done_n = nxt == shift_register_pkg::DONE;
    busy_n = nxt != IDLE;
    gnt_n = nxt == IDLE ? '0 : (state == IDLE ? arb_oh : win_oh);
  end
  always_ff @(posedge C) begin
    if (R) begin
      L <= 1'b0;
      SE <= 1'b0;
      DONE <= 1'b0;
      BUSY <= 1'b0;
      GNT <= '0;
    end else begin
      L <= l_n;
      SE <= se_n;
      DONE <= done_n;
      BUSY <= busy_n;
      GNT <= gnt_n;
    end
  end
  always_ff @(posedge C) begin
    if (R) begin
      cnt <= '0;
      ptr <= '0;
      D <= '0;
      win_oh <= '0;
      win_idx <= '0;
      RESULT <= '0;
    end else begin
      if (state == IDLE && |REQ) begin
        D <= DIN[arb_idx*WIDTH +: WIDTH];
        win_oh <= arb_oh;
        win_idx <= arb_idx;
      end
      if (state == LOAD) cnt <= CW'(SHIFTS);
      else if (state == SHIFT) cnt <= cnt - 1'b1;
      if (state == shift_register_pkg::DONE) begin
        RESULT <= Q;
        ptr <= win_idx == IW'(NREQ - 1) ? '0 : win_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_shift_register_scheduler.sv
// tb_shift_register_scheduler: scoreboard bench with a behavioural shift register and arbitration model
module tb_shift_register_scheduler;
  localparam int W = 4, N = 2, S = 4, DW = N * W;
  logic C = 1'b0, R = 1'b1;
  logic [N-1:0] REQ = '0, REQ0 = '0;
  logic [DW-1:0] DIN = '0;
  logic [W-1:0] Q, Q0, D, D0, RESULT, RESULT0;
  logic L, SE, BUSY, DONE, L0, SE0, BUSY0, DONE0;
  logic [N-1:0] GNT, GNT0;
  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] word;
    logic [W-1:0] res;
    int due;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int n_chk = 0, n_pass = 0, tick = 0, ptr_m = 0, se_n = 0, cyc = 0;
  bit active = 0, res_pend = 0;

  always #5 C = ~C;

  shift_register_scheduler #(.WIDTH(W), .NREQ(N), .SHIFTS(S)) dut (
    .C(C), .R(R), .REQ(REQ), .DIN(DIN), .Q(Q), .L(L), .SE(SE), .D(D),
    .GNT(GNT), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT));
  shift_register_scheduler #(.WIDTH(W), .NREQ(N), .SHIFTS(0)) dut0 (
    .C(C), .R(R), .REQ(REQ0), .DIN(DIN), .Q(Q0), .L(L0), .SE(SE0), .D(D0),
    .GNT(GNT0), .BUSY(BUSY0), .DONE(DONE0), .RESULT(RESULT0));

  // Shift register datapath: Johnson-style shift so each shift count yields a distinct word.
  always @(posedge C) if (L) Q <= D; else if (SE) Q <= {Q[W-2:0], ~Q[W-1]};
  always @(posedge C) if (L0) Q0 <= D0; else if (SE0) Q0 <= {Q0[W-2:0], ~Q0[W-1]};

  function automatic logic [W-1:0] johnson(input logic [W-1:0] w, input int n);
    logic [W-1:0] v = w;
    for (int i = 0; i < n; i++) v = {v[W-2:0], ~v[W-1]};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] req, input logic [DW-1:0] din);
    exp_t e;
    int win;
    R = r;
    REQ = req;
    DIN = din;
    if (r) ptr_m = 0;
    else if (!BUSY && req != 0) begin
      win = 0;
      for (int k = 0; k < N; k++)
        if (req[(ptr_m + k) % N]) begin
          win = (ptr_m + k) % N;
          break;
        end
      e.gnt = N'(1) << win;
      e.word = din[win*W +: W];
      e.res = johnson(e.word, S);
      e.due = tick + 2;
      exp_q.push_back(e);
      ptr_m = (win + 1) % N;
    end
    @(posedge C);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * S + 10 && BUSY; i++) cycle(1'b0, '0, DW'($urandom));
    chk("drain_busy", 32'(BUSY), 0);
    cycle(1'b0, '0, DW'($urandom));
  endtask

  initial forever begin
    @(negedge C);
    tick++;
    if (R) begin
      exp_q.delete();
      active = 0;
      res_pend = 0;
    end else begin
      chk("l_se_excl", 32'(L & SE), 0);
      if (res_pend) begin
        chk("result", 32'(RESULT), 32'(cur.res));
        chk("busy_after_done", 32'(BUSY), 0);
        res_pend = 0;
      end
      if (L) begin
        if (exp_q.size() == 0) chk("unexpected_load", 32'(L), 0);
        else begin
          cur = exp_q.pop_front();
          chk("load_latency", 32'(tick), 32'(cur.due));
          chk("gnt_load", 32'(GNT), 32'(cur.gnt));
          chk("d_load", 32'(D), 32'(cur.word));
          chk("busy_load", 32'(BUSY), 1);
          active = 1;
          se_n = 0;
          cyc = 0;
        end
      end else if (active) begin
        cyc++;
        if (SE) se_n++;
        chk("gnt_hold", 32'(GNT), 32'(cur.gnt));
        chk("d_hold", 32'(D), 32'(cur.word));
        if (DONE) begin
          chk("se_cycles", 32'(se_n), S);
          chk("done_latency", 32'(cyc), S + 1);
          active = 0;
          res_pend = 1;
        end else if (cyc > S + 1) begin
          chk("done_timeout", 32'(DONE), 1);
          active = 0;
        end
      end else chk("idle_quiet", {29'd0, SE, DONE, 1'b0} | 32'(GNT), 0);
    end
  end

  initial begin
    logic [W-1:0] w;
    repeat (2) cycle(1'b1, '0, DW'($urandom));
    repeat (12) cycle(1'b0, N'($urandom), DW'($urandom));
    cycle(1'b1, '0, DW'($urandom));
    cycle(1'b1, '0, DW'($urandom));
    chk("rst_ctrl", {28'd0, L, SE, DONE, BUSY}, 0);
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_d", 32'(D), 0);
    chk("rst_result", 32'(RESULT), 0);
    cycle(1'b0, 2'b01, {W'($urandom), 4'b1011});
    drain();
    repeat (3 * (S + 3)) cycle(1'b0, 2'b11, DW'($urandom));
    drain();
    cycle(1'b0, 2'b11, DW'($urandom));
    cycle(1'b0, '0, DW'($urandom));
    cycle(1'b0, '0, DW'($urandom));
    cycle(1'b1, '0, DW'($urandom));
    chk("abort_outs", {28'd0, L, SE, DONE, BUSY}, 0);
    chk("abort_gnt", 32'(GNT), 0);
    cycle(1'b0, 2'b11, DW'($urandom));
    drain();
    cycle(1'b0, 2'b10, DW'($urandom));
    drain();
    repeat (400) cycle($urandom_range(0, 39) == 0, N'($urandom), DW'($urandom));
    cycle(1'b0, '0, DW'($urandom));
    drain();
    w = W'($urandom);
    REQ0 = 2'b01;
    cycle(1'b0, '0, {W'($urandom), w});
    REQ0 = '0;
    chk("s0_load", {28'd0, L0, SE0, BUSY0, DONE0}, 32'b1010);
    chk("s0_d", 32'(D0), 32'(w));
    chk("s0_gnt_load", 32'(GNT0), 1);
    cycle(1'b0, '0, DW'($urandom));
    chk("s0_done", {28'd0, L0, SE0, BUSY0, DONE0}, 32'b0011);
    chk("s0_gnt_done", 32'(GNT0), 1);
    cycle(1'b0, '0, DW'($urandom));
    chk("s0_after", {28'd0, L0, SE0, BUSY0, DONE0}, 0);
    chk("s0_result", 32'(RESULT0), 32'(w));
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("monitor_idle", {30'd0, active, res_pend}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
